hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It consumes the register-address and control fields leaving IF/ID, ID/EX, EX/MEM and MEM/WB, and drives write-enable and flush inputs on every pipeline register and the PC. It also produces the EX-stage forwarding selects. It freezes the pipeline on data-memory wait states, inserts load-use bubbles, squashes wrong-path instructions on taken branches, and keeps stall/flush statistics plus a memory-timeout watchdog.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_ctrl_fwd_unit.sv | 29 ++
 rtl/hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// forwarding select constants and a register-match helper.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // True when a non-x0 destination register feeds the given source register.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-stage forwarding select for a single ALU operand. The younger result
// (EX/MEM) takes precedence over the older one (MEM/WB).
module fwd_unit
  import hazard_pkg::*;
(
  input  logic       rst,
  input  logic [4:0] id_ex_rs,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_reg_write,
  input  logic [4:0] mem_wb_rd,
  input  logic       mem_wb_reg_write,
  output logic [1:0] fwd_sel
);

  // Pick the newest in-flight producer of this operand, register file otherwise.
  always_comb begin
    fwd_sel = FWD_RF;
    if (rst) begin
      fwd_sel = FWD_RF;
    end else if (ex_mem_reg_write && reg_match(ex_mem_rd, id_ex_rs)) begin
      fwd_sel = FWD_MEM;
    end else if (mem_wb_reg_write && reg_match(mem_wb_rd, id_ex_rs)) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: memory freeze, branch
// squash, load-use bubble, operand forwarding, statistics and a watchdog.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_RS1,
  input  logic [4:0]       IF_ID_RS2,
  input  logic [4:0]       ID_EX_RS1,
  input  logic [4:0]       ID_EX_RS2,
  input  logic [4:0]       ID_EX_RD,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       EX_MEM_RD,
  input  logic             EX_MEM_RegWrite,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             EX_MEM_Branch,
  input  logic             EX_MEM_Zero,
  input  logic [4:0]       MEM_WB_RD,
  input  logic             MEM_WB_RegWrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout,
  output logic             hz_state
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_SAT = {WAIT_W{1'b1}};

  hz_state_e         state_r;
  hz_state_e         state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_timeout_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic              memstall_s;
  logic              taken_s;
  logic              loaduse_s;
  logic              stall_inc_s;
  logic              flush_inc_s;

  // Hazard conditions; loaduse conservatively checks rs2 for every format.
  always_comb begin
    memstall_s = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~dmem_ready;
    taken_s    = EX_MEM_Branch & EX_MEM_Zero;
    loaduse_s  = ID_EX_MemRead &
                 (reg_match(ID_EX_RD, IF_ID_RS1) | reg_match(ID_EX_RD, IF_ID_RS2));
  end

  // Next state and pipeline controls: memstall > taken > loaduse > normal.
  always_comb begin
    state_nxt_s  = state_r;
    pc_write     = 1'b0;
    IF_ID_write  = 1'b0;
    ID_EX_write  = 1'b0;
    EX_MEM_write = 1'b0;
    MEM_WB_write = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    stall_inc_s  = 1'b0;
    flush_inc_s  = 1'b0;
    if (rst) begin
      state_nxt_s = RUN;
    end else begin
      if (memstall_s) begin
        // A taken branch here is deferred until the freeze releases.
        stall_inc_s = 1'b1;
      end else if (taken_s) begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
        EX_MEM_flush = 1'b1;
        flush_inc_s  = 1'b1;
      end else if (loaduse_s) begin
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        ID_EX_flush  = 1'b1;
        stall_inc_s  = 1'b1;
      end else begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
      end
      case (state_r)
        RUN:      state_nxt_s = memstall_s ? MEM_WAIT : RUN;
        MEM_WAIT: state_nxt_s = memstall_s ? MEM_WAIT : RUN;
        default:  state_nxt_s = RUN;
      endcase
    end
  end

  // FSM state, wait-cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (memstall_s) begin
        if (state_r == RUN) begin
          wait_cnt_r <= {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
          if (wait_cnt_r != WAIT_SAT) begin
            wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
          if (wait_cnt_r == WAIT_LIM) begin
            mem_timeout_r <= 1'b1;
          end else begin
            mem_timeout_r <= mem_timeout_r;
          end
        end
      end else begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end
    end
  end

  // Stall and flush statistics, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_inc_s) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;
  assign mem_timeout = mem_timeout_r;
  assign hz_state    = state_r;

  fwd_unit u_fwd_a (
    .rst              (rst),
    .id_ex_rs         (ID_EX_RS1),
    .ex_mem_rd        (EX_MEM_RD),
    .ex_mem_reg_write (EX_MEM_RegWrite),
    .mem_wb_rd        (MEM_WB_RD),
    .mem_wb_reg_write (MEM_WB_RegWrite),
    .fwd_sel          (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rst              (rst),
    .id_ex_rs         (ID_EX_RS2),
    .ex_mem_rd        (EX_MEM_RD),
    .ex_mem_reg_write (EX_MEM_RegWrite),
    .mem_wb_rd        (MEM_WB_RD),
    .mem_wb_reg_write (MEM_WB_RegWrite),
    .fwd_sel          (fwd_b)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  IF_ID_RS1, IF_ID_RS2, ID_EX_RS1, ID_EX_RS2, ID_EX_RD;
  logic        ID_EX_MemRead;
  logic [4:0]  EX_MEM_RD;
  logic        EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite;
  logic        EX_MEM_Branch, EX_MEM_Zero;
  logic [4:0]  MEM_WB_RD;
  logic        MEM_WB_RegWrite, dmem_ready;
  logic        pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
  logic        IF_ID_flush, ID_EX_flush, EX_MEM_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;
  logic        mem_timeout, hz_state;

  int vectors = 0;
  int misses  = 0;

  hazard_ctrl #(.WAIT_MAX(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2),
    .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2), .ID_EX_RD(ID_EX_RD),
    .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_RD(EX_MEM_RD), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_Zero(EX_MEM_Zero),
    .MEM_WB_RD(MEM_WB_RD), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
    .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout), .hz_state(hz_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed view of controls: {pc,ifid,idex,exmem,memwb writes, ifid,idex,exmem flushes}
  function automatic logic [7:0] ctl();
    return {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
            IF_ID_flush, ID_EX_flush, EX_MEM_flush};
  endfunction

  task automatic clear_inputs();
    IF_ID_RS1 = 5'd0; IF_ID_RS2 = 5'd0; ID_EX_RS1 = 5'd0; ID_EX_RS2 = 5'd0;
    ID_EX_RD = 5'd0; ID_EX_MemRead = 1'b0; EX_MEM_RD = 5'd0;
    EX_MEM_RegWrite = 1'b0; EX_MEM_MemRead = 1'b0; EX_MEM_MemWrite = 1'b0;
    EX_MEM_Branch = 1'b0; EX_MEM_Zero = 1'b0; MEM_WB_RD = 5'd0;
    MEM_WB_RegWrite = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Forwarding would match, but reset forces everything quiet.
    ID_EX_RS1 = 5'd3; EX_MEM_RD = 5'd3; EX_MEM_RegWrite = 1'b1;
    tick();
    chk("rst_ctl", {24'd0, ctl()}, 32'h00);
    chk("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("idle_ctl", {24'd0, ctl()}, 32'hF8);
    chk("idle_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("idle_stall", stall_cnt, 32'd0);
    chk("idle_flush", flush_cnt, 32'd0);
    chk("idle_state", {31'd0, hz_state}, 32'd0);
    chk("idle_tmo", {31'd0, mem_timeout}, 32'd0);

    // Load-use on rs2.
    ID_EX_MemRead = 1'b1; ID_EX_RD = 5'd5; IF_ID_RS2 = 5'd5;
    #1 chk("lu_ctl", {24'd0, ctl()}, 32'h3A);
    tick();
    clear_inputs();
    #1 chk("lu_stall", stall_cnt, 32'd1);

    // Load into x0 never stalls.
    ID_EX_MemRead = 1'b1; ID_EX_RD = 5'd0;
    #1 chk("lu_x0_ctl", {24'd0, ctl()}, 32'hF8);
    tick();
    chk("lu_x0_stall", stall_cnt, 32'd1);

    // Taken branch wins over load-use.
    ID_EX_RD = 5'd5; IF_ID_RS1 = 5'd5; EX_MEM_Branch = 1'b1; EX_MEM_Zero = 1'b1;
    #1 chk("br_ctl", {24'd0, ctl()}, 32'hFF);
    tick();
    clear_inputs();
    #1 chk("br_flush", flush_cnt, 32'd1);
    chk("br_stall", stall_cnt, 32'd1);

    // Three frozen cycles, then release.
    EX_MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    #1 chk("ms1_ctl", {24'd0, ctl()}, 32'h00);
    chk("ms1_state", {31'd0, hz_state}, 32'd0);
    tick();
    chk("ms2_ctl", {24'd0, ctl()}, 32'h00);
    chk("ms2_state", {31'd0, hz_state}, 32'd1);
    tick();
    chk("ms3_state", {31'd0, hz_state}, 32'd1);
    tick();
    chk("ms_stall", stall_cnt, 32'd4);
    dmem_ready = 1'b1;
    #1 chk("ms4_ctl", {24'd0, ctl()}, 32'hF8);
    tick();
    chk("ms_done_state", {31'd0, hz_state}, 32'd0);
    chk("ms_done_stall", stall_cnt, 32'd4);

    // Taken branch during a freeze is deferred to the release cycle.
    dmem_ready = 1'b0; EX_MEM_Branch = 1'b1; EX_MEM_Zero = 1'b1;
    #1 chk("dbr_frz_ctl", {24'd0, ctl()}, 32'h00);
    tick();
    dmem_ready = 1'b1;
    #1 chk("dbr_rel_ctl", {24'd0, ctl()}, 32'hFF);
    tick();
    clear_inputs();
    #1 chk("dbr_flush", flush_cnt, 32'd2);
    chk("dbr_stall", stall_cnt, 32'd5);
    chk("dbr_state", {31'd0, hz_state}, 32'd0);

    // Access completing in the same cycle causes no freeze.
    EX_MEM_MemWrite = 1'b1; dmem_ready = 1'b1;
    #1 chk("rdy_ctl", {24'd0, ctl()}, 32'hF8);
    tick();
    chk("rdy_state", {31'd0, hz_state}, 32'd0);
    chk("rdy_stall", stall_cnt, 32'd5);
    clear_inputs();

    // Watchdog: sets after the 17th frozen edge, sticky through release.
    EX_MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 16) chk("tmo_16", {31'd0, mem_timeout}, 32'd0);
      if (i == 17) chk("tmo_17", {31'd0, mem_timeout}, 32'd1);
    end
    chk("tmo_frozen_ctl", {24'd0, ctl()}, 32'h00);
    dmem_ready = 1'b1;
    tick();
    clear_inputs();
    #1 chk("tmo_sticky", {31'd0, mem_timeout}, 32'd1);
    chk("tmo_state", {31'd0, hz_state}, 32'd0);
    chk("tmo_stall", stall_cnt, 32'd25);

    // Forwarding selects.
    EX_MEM_RD = 5'd7; MEM_WB_RD = 5'd7; ID_EX_RS1 = 5'd7;
    EX_MEM_RegWrite = 1'b1; MEM_WB_RegWrite = 1'b1;
    #1 chk("fwd_a_mem", {30'd0, fwd_a}, 32'd2);
    chk("fwd_b_rf", {30'd0, fwd_b}, 32'd0);
    ID_EX_RS2 = 5'd7;
    #1 chk("fwd_b_mem", {30'd0, fwd_b}, 32'd2);
    EX_MEM_RegWrite = 1'b0;
    #1 chk("fwd_a_wb", {30'd0, fwd_a}, 32'd1);
    EX_MEM_RegWrite = 1'b1; EX_MEM_RD = 5'd0; MEM_WB_RD = 5'd0;
    ID_EX_RS1 = 5'd0; ID_EX_RS2 = 5'd0;
    #1 chk("fwd_x0", {28'd0, fwd_a, fwd_b}, 32'd0);
    clear_inputs();

    // Reset while in MEM_WAIT returns to RUN and clears everything.
    EX_MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    tick();
    chk("rstw_pre_state", {31'd0, hz_state}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rstw_state", {31'd0, hz_state}, 32'd0);
    chk("rstw_tmo", {31'd0, mem_timeout}, 32'd0);
    chk("rstw_stall", stall_cnt, 32'd0);
    chk("rstw_flush", flush_cnt, 32'd0);
    rst = 1'b0;
    clear_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
